// File: rtl/issue_stage_pkg.sv
// Shared pipeline definitions: decoded control layout, functional-unit indices,
// register-file geometry and a small register-select helper.
package issue_stage_pkg;

    localparam int CTRL_W   = 13;
    localparam int NUM_FU   = 4;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_SHIFT  = 2'd1,
        FU_MEM    = 2'd2,
        FU_BRANCH = 2'd3
    } fu_e;

    // Field order fixes the bit positions, MSB first.
    typedef struct packed {
        logic       selalushift;
        logic       selimregb;
        logic [2:0] aluop;
        logic       unsig;
        logic [1:0] shiftop;
        logic       readmem;
        logic       writemem;
        logic       selwsource;
        logic       writereg;
        logic       writeov;
    } ctrl_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
    endfunction

endpackage

// File: rtl/issue_stage_hazard_check.sv
// Scoreboard lookup: flags read-after-write and write-after-write hazards
// against the (already writeback-adjusted) pending vector.
module hazard_check
    import issue_stage_pkg::*;
(
    input  logic [NUM_REGS-1:0] pending_i,
    input  logic [REG_W-1:0]    addra_i,
    input  logic [REG_W-1:0]    addrb_i,
    input  logic [REG_W-1:0]    regdest_i,
    input  logic                writereg_i,
    input  logic [1:0]          numop_i,
    output logic                raw_o,
    output logic                waw_o
);

    logic use_a;
    logic use_b;

    // numop of 3 behaves like 2, so bit 1 alone selects operand B.
    assign use_a = (numop_i != 2'd0);
    assign use_b = numop_i[1];

    assign raw_o = (use_a && (addra_i != '0) && pending_i[addra_i]) ||
                   (use_b && (addrb_i != '0) && pending_i[addrb_i]);

    assign waw_o = writereg_i && (regdest_i != '0) && pending_i[regdest_i];

endmodule

// File: rtl/issue_stage.sv
// In-order issue stage: scoreboard hazard detection, register-file read and
// a one-cycle registered issue packet towards the execution units.
module issue_stage
    import issue_stage_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [CTRL_W-1:0]   id_is_ctrl,
    input  logic [DATA_W-1:0]   id_is_imedext,
    input  logic [REG_W-1:0]    id_is_regdest,
    input  logic [1:0]          id_is_numop,
    input  logic [1:0]          id_is_fununit,
    input  logic [DATA_W-1:0]   id_is_addra,
    input  logic [DATA_W-1:0]   id_is_addrb,
    output logic                is_if_stall,
    output logic [REG_W-1:0]    is_reg_addra,
    output logic [REG_W-1:0]    is_reg_addrb,
    input  logic [DATA_W-1:0]   reg_is_dataa,
    input  logic [DATA_W-1:0]   reg_is_datab,
    input  logic [NUM_FU-1:0]   ex_is_busy,
    input  logic                wb_is_writereg,
    input  logic [REG_W-1:0]    wb_is_regdest,
    output logic                is_ex_valid,
    output logic [1:0]          is_ex_fununit,
    output logic [CTRL_W-1:0]   is_ex_ctrl,
    output logic [REG_W-1:0]    is_ex_regdest,
    output logic [DATA_W-1:0]   is_ex_dataa,
    output logic [DATA_W-1:0]   is_ex_datab,
    output logic [DATA_W-1:0]   is_ex_imedext
);

    ctrl_t               ctrl;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] pending_eff;
    logic [NUM_REGS-1:0] wb_clear;
    logic                raw, waw, struct_haz;
    logic                sets_dest;
    logic                unused_addr_hi;

    logic                valid_q;
    logic [1:0]          fununit_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic [REG_W-1:0]    regdest_q;
    logic [DATA_W-1:0]   dataa_q, datab_q, imedext_q;

    assign ctrl = ctrl_t'(id_is_ctrl);

    // Register numbers live in the low five bits only.
    assign is_reg_addra   = id_is_addra[REG_W-1:0];
    assign is_reg_addrb   = id_is_addrb[REG_W-1:0];
    assign unused_addr_hi = ^{id_is_addra[DATA_W-1:REG_W], id_is_addrb[DATA_W-1:REG_W]};

    // A writeback landing this cycle already releases its register.
    assign wb_clear    = wb_is_writereg ? reg_onehot(wb_is_regdest) : '0;
    assign pending_eff = pending_q & ~wb_clear;

    hazard_check u_hazard_check (
        .pending_i  (pending_eff),
        .addra_i    (is_reg_addra),
        .addrb_i    (is_reg_addrb),
        .regdest_i  (id_is_regdest),
        .writereg_i (ctrl.writereg),
        .numop_i    (id_is_numop),
        .raw_o      (raw),
        .waw_o      (waw)
    );

    assign struct_haz  = ex_is_busy[id_is_fununit];
    assign is_if_stall = raw || waw || struct_haz;

    assign sets_dest = !is_if_stall && ctrl.writereg && (id_is_regdest != '0);

    // The issue-time set is applied after the writeback clear so it wins.
    always_comb begin
        pending_d = pending_eff;
        if (sets_dest) begin
            pending_d = pending_d | reg_onehot(id_is_regdest);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            fununit_q <= '0;
            ctrl_q    <= '0;
            regdest_q <= '0;
            dataa_q   <= '0;
            datab_q   <= '0;
            imedext_q <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= !is_if_stall;
            if (!is_if_stall) begin
                fununit_q <= id_is_fununit;
                ctrl_q    <= id_is_ctrl;
                regdest_q <= id_is_regdest;
                dataa_q   <= reg_is_dataa;
                datab_q   <= reg_is_datab;
                imedext_q <= id_is_imedext;
            end
        end
    end

    assign is_ex_valid   = valid_q;
    assign is_ex_fununit = fununit_q;
    assign is_ex_ctrl    = ctrl_q;
    assign is_ex_regdest = regdest_q;
    assign is_ex_dataa   = dataa_q;
    assign is_ex_datab   = datab_q;
    assign is_ex_imedext = imedext_q;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: a register-level scoreboard model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_issue_stage;

    logic        clock;
    logic        reset;
    logic [12:0] id_is_ctrl;
    logic [31:0] id_is_imedext;
    logic [4:0]  id_is_regdest;
    logic [1:0]  id_is_numop;
    logic [1:0]  id_is_fununit;
    logic [31:0] id_is_addra;
    logic [31:0] id_is_addrb;
    logic        is_if_stall;
    logic [4:0]  is_reg_addra;
    logic [4:0]  is_reg_addrb;
    logic [31:0] reg_is_dataa;
    logic [31:0] reg_is_datab;
    logic [3:0]  ex_is_busy;
    logic        wb_is_writereg;
    logic [4:0]  wb_is_regdest;
    logic        is_ex_valid;
    logic [1:0]  is_ex_fununit;
    logic [12:0] is_ex_ctrl;
    logic [4:0]  is_ex_regdest;
    logic [31:0] is_ex_dataa;
    logic [31:0] is_ex_datab;
    logic [31:0] is_ex_imedext;

    int vec = 0;
    int bad = 0;

    issue_stage dut (
        .clock          (clock),
        .reset          (reset),
        .id_is_ctrl     (id_is_ctrl),
        .id_is_imedext  (id_is_imedext),
        .id_is_regdest  (id_is_regdest),
        .id_is_numop    (id_is_numop),
        .id_is_fununit  (id_is_fununit),
        .id_is_addra    (id_is_addra),
        .id_is_addrb    (id_is_addrb),
        .is_if_stall    (is_if_stall),
        .is_reg_addra   (is_reg_addra),
        .is_reg_addrb   (is_reg_addrb),
        .reg_is_dataa   (reg_is_dataa),
        .reg_is_datab   (reg_is_datab),
        .ex_is_busy     (ex_is_busy),
        .wb_is_writereg (wb_is_writereg),
        .wb_is_regdest  (wb_is_regdest),
        .is_ex_valid    (is_ex_valid),
        .is_ex_fununit  (is_ex_fununit),
        .is_ex_ctrl     (is_ex_ctrl),
        .is_ex_regdest  (is_ex_regdest),
        .is_ex_dataa    (is_ex_dataa),
        .is_ex_datab    (is_ex_datab),
        .is_ex_imedext  (is_ex_imedext)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          busy_reg [32];   // register awaits a writeback
    logic        exp_valid = 1'b0;
    logic [1:0]  exp_fu    = '0;
    logic [12:0] exp_ctrl  = '0;
    logic [4:0]  exp_rd    = '0;
    logic [31:0] exp_a     = '0;
    logic [31:0] exp_b     = '0;
    logic [31:0] exp_imm   = '0;

    function automatic bit still_waiting(int r);
        return busy_reg[r] && !(wb_is_writereg && (int'(wb_is_regdest) == r));
    endfunction

    function automatic bit model_stall();
        int  nsrc;
        int  ra;
        int  rb;
        int  rd;
        bit  hazard;
        nsrc   = (id_is_numop == 2'd0) ? 0 : (id_is_numop == 2'd1) ? 1 : 2;
        ra     = int'(id_is_addra % 32);
        rb     = int'(id_is_addrb % 32);
        rd     = int'(id_is_regdest);
        hazard = 0;
        if (nsrc >= 1 && ra != 0 && still_waiting(ra)) hazard = 1;
        if (nsrc >= 2 && rb != 0 && still_waiting(rb)) hazard = 1;
        if (id_is_ctrl[1] && rd != 0 && still_waiting(rd)) hazard = 1;
        if (ex_is_busy[id_is_fununit]) hazard = 1;
        return hazard;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            foreach (busy_reg[i]) busy_reg[i] = 0;
            exp_valid = 0; exp_fu = 0; exp_ctrl = 0; exp_rd = 0;
            exp_a = 0; exp_b = 0; exp_imm = 0;
        end else begin
            bit st;
            st = model_stall();
            if (wb_is_writereg) busy_reg[wb_is_regdest] = 0;
            if (!st) begin
                exp_valid = 1;
                exp_fu    = id_is_fununit;
                exp_ctrl  = id_is_ctrl;
                exp_rd    = id_is_regdest;
                exp_a     = reg_is_dataa;
                exp_b     = reg_is_datab;
                exp_imm   = id_is_imedext;
                if (id_is_ctrl[1] && id_is_regdest != 0) busy_reg[id_is_regdest] = 1;
            end else begin
                exp_valid = 0;
            end
            busy_reg[0] = 0;
        end
    end

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            chk("m_stall",   {31'd0, is_if_stall}, {31'd0, model_stall()});
            chk("m_addra",   {27'd0, is_reg_addra}, id_is_addra % 32);
            chk("m_addrb",   {27'd0, is_reg_addrb}, id_is_addrb % 32);
            chk("m_valid",   {31'd0, is_ex_valid}, {31'd0, exp_valid});
            chk("m_fununit", {30'd0, is_ex_fununit}, {30'd0, exp_fu});
            chk("m_ctrl",    {19'd0, is_ex_ctrl}, {19'd0, exp_ctrl});
            chk("m_regdest", {27'd0, is_ex_regdest}, {27'd0, exp_rd});
            chk("m_dataa",   is_ex_dataa, exp_a);
            chk("m_datab",   is_ex_datab, exp_b);
            chk("m_imedext", is_ex_imedext, exp_imm);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ins(input logic [12:0] c, input logic [4:0] rd, input logic [1:0] nop,
                           input logic [1:0] fu, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] da, input logic [31:0] db);
        id_is_ctrl    = c;
        id_is_regdest = rd;
        id_is_numop   = nop;
        id_is_fununit = fu;
        id_is_addra   = a;
        id_is_addrb   = b;
        id_is_imedext = imm;
        reg_is_dataa  = da;
        reg_is_datab  = db;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, is_ex_valid}, 32'd0);
        chk({tag, "_ctrl"},  {19'd0, is_ex_ctrl}, 32'd0);
        chk({tag, "_rd"},    {27'd0, is_ex_regdest}, 32'd0);
        chk({tag, "_fu"},    {30'd0, is_ex_fununit}, 32'd0);
        chk({tag, "_dataa"}, is_ex_dataa, 32'd0);
        chk({tag, "_datab"}, is_ex_datab, 32'd0);
        chk({tag, "_imm"},   is_ex_imedext, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        set_ins('0, '0, '0, '0, '0, '0, '0, '0, '0);
        ex_is_busy = '0;
        wb_is_writereg = 1'b0;
        wb_is_regdest = '0;
        #1 reset = 1'b0;
        #1;
        chk_all_zero("rst");
        chk("rst_stall", {31'd0, is_if_stall}, 32'd0);
        step();
        step();
        reset = 1'b1;

        // addi r5 then add r6,r5,r5: RAW until r5 writes back
        set_ins(13'h802, 5'd5, 2'd1, 2'd0, 32'd0, 32'd0, 32'd10, 32'd0, 32'd0);
        #1 chk("addi_stall", {31'd0, is_if_stall}, 32'd0);
        step();
        chk("addi_valid", {31'd0, is_ex_valid}, 32'd1);
        chk("addi_rd", {27'd0, is_ex_regdest}, 32'd5);
        set_ins(13'h002, 5'd6, 2'd2, 2'd0, 32'd5, 32'd5, 32'd0, 32'd11, 32'd22);
        #1 chk("raw_stall", {31'd0, is_if_stall}, 32'd1);
        step();
        chk("raw_valid0", {31'd0, is_ex_valid}, 32'd0);
        step();
        chk("raw_hold_rd", {27'd0, is_ex_regdest}, 32'd5);
        wb_is_writereg = 1'b1; wb_is_regdest = 5'd5;
        #1 chk("raw_wb_unblock", {31'd0, is_if_stall}, 32'd0);
        step();
        wb_is_writereg = 1'b0;
        chk("add_valid", {31'd0, is_ex_valid}, 32'd1);
        chk("add_rd", {27'd0, is_ex_regdest}, 32'd6);
        chk("add_datab", is_ex_datab, 32'd22);

        // structural hazard on unit 2
        set_ins(13'h010, 5'd0, 2'd1, 2'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        ex_is_busy = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1 chk("busy_stall", {31'd0, is_if_stall}, 32'd1);
            step();
            chk("busy_valid0", {31'd0, is_ex_valid}, 32'd0);
        end
        ex_is_busy = 4'b1011;
        #1 chk("other_busy_nostall", {31'd0, is_if_stall}, 32'd0);
        step();
        ex_is_busy = 4'b0000;
        chk("mem_valid", {31'd0, is_ex_valid}, 32'd1);
        chk("mem_fu", {30'd0, is_ex_fununit}, 32'd2);

        // only addr[4:0] is a register number; r6 still pending
        set_ins(13'h000, 5'd0, 2'd1, 2'd0, 32'hFFFF_FFE6, 32'h0000_0040, 32'd0, 32'd0, 32'd0);
        #1 chk("addr_hi_stall", {31'd0, is_if_stall}, 32'd1);
        chk("addr_hi_port", {27'd0, is_reg_addra}, 32'd6);

        // writeback of r7 in the same cycle r7 is re-issued keeps it pending
        set_ins(13'h002, 5'd7, 2'd0, 2'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        wb_is_writereg = 1'b1; wb_is_regdest = 5'd7;
        #1 chk("waw_wb_unblock", {31'd0, is_if_stall}, 32'd0);
        step();
        wb_is_writereg = 1'b0;
        chk("r7_reissue_valid", {31'd0, is_ex_valid}, 32'd1);
        set_ins(13'h000, 5'd0, 2'd1, 2'd0, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0);
        #1 chk("r7_still_pending", {31'd0, is_if_stall}, 32'd1);
        wb_is_writereg = 1'b1; wb_is_regdest = 5'd7;
        step();
        wb_is_writereg = 1'b0;

        // fill the scoreboard (r6 is already pending)
        for (int r = 1; r < 32; r++) begin
            if (r != 6) begin
                set_ins(13'h002, 5'(r), 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
                step();
            end
        end
        set_ins(13'h002, 5'd0, 2'd1, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #1 chk("r0_nostall", {31'd0, is_if_stall}, 32'd0);
        step();
        chk("r0_valid", {31'd0, is_ex_valid}, 32'd1);
        set_ins(13'h000, 5'd0, 2'd2, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #1 chk("r0_never_pending", {31'd0, is_if_stall}, 32'd0);
        set_ins(13'h000, 5'd0, 2'd3, 2'd0, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0);
        #1 chk("numop3_uses_b", {31'd0, is_if_stall}, 32'd1);
        id_is_numop = 2'd1;
        #1 chk("numop1_ignores_b", {31'd0, is_if_stall}, 32'd0);

        // all-zero packet and operand capture
        set_ins('0, '0, '0, '0, '0, '0, '0, '0, '0);
        step();
        chk("nop_valid", {31'd0, is_ex_valid}, 32'd1);
        set_ins(13'h000, 5'd0, 2'd0, 2'd3, 32'd0, 32'd0, 32'hFFFF_8000, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        step();
        chk("cap_valid", {31'd0, is_ex_valid}, 32'd1);
        chk("cap_dataa", is_ex_dataa, 32'hDEAD_BEEF);
        chk("cap_imm", is_ex_imedext, 32'hFFFF_8000);
        chk("cap_fu", {30'd0, is_ex_fununit}, 32'd3);

        // reset pulse between edges clears everything immediately
        #1 reset = 1'b0;
        #1 chk_all_zero("pulse1");
        #1 reset = 1'b1;
        set_ins(13'h802, 5'd5, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        set_ins(13'h000, 5'd0, 2'd1, 2'd0, 32'd5, 32'd0, 32'd0, 32'h1234_5678, 32'd0);
        #1 chk("pend20_stall", {31'd0, is_if_stall}, 32'd1);
        reset = 1'b0;
        #1 chk_all_zero("pulse2");
        #1 reset = 1'b1;
        step();
        chk("post_rst_issue", {31'd0, is_ex_valid}, 32'd1);
        chk("post_rst_dataa", is_ex_dataa, 32'h1234_5678);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
